ibex_vrf_wb_sequencer: RTL
==========================

// Module: ibex_vrf_wb_sequencer
// PURPOSE
//  Write-back sequencer/arbiter for the vector register file (32 x VLEN-bit regs).
//  Two requesters (0 = vector ALU, 1 = vector LSU) each present one 128-bit result group.
//  Round-robin arbitration grants one group at a time, never interleaving groups.
//  The group is issued as one VLEN-bit register write per cycle, 1/2/4 regs per LMUL.
//  Exports a pending-register mask so issue logic can stall reads on in-flight writes.
// PARAMETERS
//  VLEN    32   register width in bits; beat width of the RF write port
//  NBEATS  4    max registers per group (LMUL max); group data width = NBEATS*VLEN
//  AW      5    register address width (32 vector registers)
// PORTS
//  clk_i          in   1           clock, rising edge
//  rst_i          in   1           asynchronous, active-high reset
//  flush_i        in   1           synchronous abort of in-flight group
//  req_valid_i    in   2           per-requester request valid
//  req_ready_o    out  2           per-requester accept; transfer = valid & ready
//  req_vd_i       in   2*AW        destination base register, requester r at [r*AW +: AW]
//  req_vlmul_i    in   2*3         000=1 reg, 001=2 regs, 010=4 regs, others illegal
//  req_data_i     in   2*NBEATS*VLEN  group data; beat k = [k*VLEN +: VLEN] of the slice
//  req_be_i       in   2*NBEATS*VLEN/8  byte enables; beat k = [k*VLEN/8 +: VLEN/8]
//  vrf_we_o       out  1           register write enable (registered)
//  vrf_waddr_o    out  AW          register write address (registered)
//  vrf_wdata_o    out  VLEN        register write data (registered)
//  vrf_wbe_o      out  VLEN/8      register byte enables (registered)
//  done_o         out  2           1-cycle pulse, per requester, on its group's last write
//  err_o          out  1           1-cycle pulse: accepted request was illegal, dropped
//  err_src_o      out  1           requester index of the err_o event
//  pending_o      out  32          regs of the current group not yet written (incl. current beat)
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, RR pointer = requester 0 has priority.
//  FSM IDLE -> WRITE on a legal accept; WRITE -> IDLE after last beat if no new accept.
//  WRITE -> WRITE on a back-to-back accept.
//  req_ready_o: one-hot grant, asserted only in IDLE or on the last beat of WRITE.
//  Grant: the prioritised requester if valid, else the other.
//  After any grant, priority moves to the non-granted requester.
//  Accept in cycle N: latch vd, nregs, data, be; beat counter = 0.
//  Writes occur in cycles N+1 .. N+nregs.
//  Beat k: we=1, waddr=vd+k, wdata=data beat k, wbe=be beat k.
//  A beat with all-zero be is still issued (we=1).
//  No bubble between back-to-back groups: next first write lands in N+nregs+1.
//  done_o[r] is asserted in the same cycle as requester r's last write.
//  Illegal request: vlmul not in {000,001,010}, or vd misaligned.
//  Misaligned means vd[0]!=0 when nregs=2, or vd[1:0]!=0 when nregs=4.
//  An illegal request is still accepted (ready=1) and consumes its grant and RR turn.
//  It issues no write; err_o=1 and err_src_o=r in N+1; FSM goes to/stays IDLE.
//  pending_o: in write cycle N+k (k=1..nregs), bits vd+k-1 .. vd+nregs-1 are set.
//  pending_o is 0 in IDLE; it tracks registered vrf_* timing exactly.
//  flush_i is dominant over all other inputs.
//  In the cycle flush_i is sampled: no accept (ready=0), FSM -> IDLE.
//  Next cycle: we, done, err and pending are all 0. RR pointer is unchanged by flush.
//  Async reset mid-group: everything clears immediately; no partial completion is reported.
//  vd+k never wraps: alignment guarantees vd+nregs-1 <= 31.
//  Requesters must hold inputs stable while valid & !ready; the block relies on this.
// TESTING
//  1. Reset, then r0: vd=4, vlmul=001, data beats A,B -> we at N+1 (addr 4, A),
//     N+2 (addr 5, B); done_o=01 at N+2; pending 0x30 then 0x20.
//  2. Both valid, vlmul=000, held 4 cycles -> grants alternate r0,r1,r0,r1;
//     writes back-to-back with no idle cycle.
//  3. r1: vd=8, vlmul=010, be beat2=0 -> writes addr 8..11 in 4 consecutive cycles;
//     beat2 has wbe=0 with we=1; pending 0xF00,0xE00,0xC00,0x800.
//  4. r0: vd=3, vlmul=001, then r0: vlmul=011 -> each accepted; err_o=1, err_src_o=0;
//     no we; r1 is granted next.
//  5. vlmul=010 group, flush_i on beat 2 -> next cycle we=0, pending=0, no done;
//     a new request is accepted the cycle after flush deasserts.
//  6. rst_i asserted mid-group between edges -> all outputs 0 immediately;
//     after release, r0 has priority.

Source files
------------

// File: rtl/ibex_vrf_wb_sequencer.sv
// Vector register file write-back sequencer: round-robin arbitration between the
// vector ALU and LSU, issuing each granted result group as one register write per cycle.
module ibex_vrf_wb_sequencer #(
  parameter int unsigned VLEN   = 32,
  parameter int unsigned NBEATS = 4,
  parameter int unsigned AW     = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [1:0]                   req_valid_i,
  output logic [1:0]                   req_ready_o,
  input  logic [2*AW-1:0]              req_vd_i,
  input  logic [5:0]                   req_vlmul_i,
  input  logic [2*NBEATS*VLEN-1:0]     req_data_i,
  input  logic [2*NBEATS*VLEN/8-1:0]   req_be_i,
  output logic                         vrf_we_o,
  output logic [AW-1:0]                vrf_waddr_o,
  output logic [VLEN-1:0]              vrf_wdata_o,
  output logic [VLEN/8-1:0]            vrf_wbe_o,
  output logic [1:0]                   done_o,
  output logic                         err_o,
  output logic                         err_src_o,
  output logic [2**AW-1:0]             pending_o
);

  localparam int unsigned BEW  = VLEN / 8;
  localparam int unsigned GDW  = NBEATS * VLEN;
  localparam int unsigned GBW  = NBEATS * BEW;
  localparam int unsigned BW   = $clog2(NBEATS);
  localparam int unsigned NREG = 2 ** AW;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  typedef struct packed {
    logic [AW-1:0]  vd;
    logic [BW-1:0]  last;
    logic           src;
    logic [GDW-1:0] data;
    logic [GBW-1:0] be;
  } group_t;

  state_e          state_q, state_d;
  group_t          grp_q, grp_d, emit_grp;
  logic [BW-1:0]   beat_q, beat_d;
  logic            rr_q, rr_d;

  logic            we_d, err_d, err_src_d, emit;
  logic [AW-1:0]   waddr_d;
  logic [VLEN-1:0] wdata_d;
  logic [BEW-1:0]  wbe_d;
  logic [1:0]      done_d;
  logic [NREG-1:0] pend_d;

  logic            gnt_idx, any_valid, take;
  logic [AW-1:0]   sel_vd;
  logic [2:0]      sel_vlmul;
  logic [GDW-1:0]  sel_data;
  logic [GBW-1:0]  sel_be;
  logic [BW-1:0]   sel_last;
  logic            sel_illegal;

  // Registers lo..hi inclusive; hi never wraps because groups are aligned.
  function automatic logic [NREG-1:0] span_mask(input logic [AW-1:0] lo,
                                                input logic [AW-1:0] hi);
    logic [NREG-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      m[i] = (AW'(i) >= lo) && (AW'(i) <= hi);
    end
    return m;
  endfunction

  // Round-robin pick and decode of the granted requester's group
  always_comb begin
    any_valid = |req_valid_i;
    gnt_idx   = req_valid_i[rr_q] ? rr_q : ~rr_q;
    sel_vd    = gnt_idx ? req_vd_i[AW +: AW]       : req_vd_i[0 +: AW];
    sel_vlmul = gnt_idx ? req_vlmul_i[3 +: 3]      : req_vlmul_i[0 +: 3];
    sel_data  = gnt_idx ? req_data_i[GDW +: GDW]   : req_data_i[0 +: GDW];
    sel_be    = gnt_idx ? req_be_i[GBW +: GBW]     : req_be_i[0 +: GBW];
    sel_last    = '0;
    sel_illegal = 1'b0;
    case (sel_vlmul)
      3'b000: begin sel_last = BW'(0); sel_illegal = 1'b0;          end
      3'b001: begin sel_last = BW'(1); sel_illegal = sel_vd[0];     end
      3'b010: begin sel_last = BW'(3); sel_illegal = |sel_vd[1:0];  end
      default: begin sel_last = BW'(0); sel_illegal = 1'b1;         end
    endcase
    take        = !flush_i && any_valid &&
                  ((state_q == IDLE) || (beat_q == grp_q.last));
    req_ready_o = take ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    beat_d    = beat_q;
    rr_d      = rr_q;
    emit      = 1'b0;
    emit_grp  = grp_q;
    we_d      = 1'b0;
    waddr_d   = '0;
    wdata_d   = '0;
    wbe_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    err_src_d = 1'b0;
    pend_d    = '0;

    if (flush_i) begin
      state_d = IDLE;
    end else if (state_q == WRITE && beat_q != grp_q.last) begin
      beat_d = beat_q + BW'(1);
      emit   = 1'b1;
    end else if (take) begin
      rr_d = ~gnt_idx;
      if (sel_illegal) begin
        state_d   = IDLE;
        err_d     = 1'b1;
        err_src_d = gnt_idx;
      end else begin
        grp_d.vd   = sel_vd;
        grp_d.last = sel_last;
        grp_d.src  = gnt_idx;
        grp_d.data = sel_data;
        grp_d.be   = sel_be;
        beat_d     = '0;
        state_d    = WRITE;
        emit       = 1'b1;
        emit_grp   = grp_d;
      end
    end else begin
      state_d = IDLE;
    end

    if (emit) begin
      we_d    = 1'b1;
      waddr_d = emit_grp.vd + AW'(beat_d);
      wdata_d = emit_grp.data[32'(beat_d) * VLEN +: VLEN];
      wbe_d   = emit_grp.be[32'(beat_d) * BEW +: BEW];
      pend_d  = span_mask(waddr_d, emit_grp.vd + AW'(emit_grp.last));
      if (beat_d == emit_grp.last) begin
        done_d[emit_grp.src] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      beat_q      <= '0;
      rr_q        <= 1'b0;
      vrf_we_o    <= 1'b0;
      vrf_waddr_o <= '0;
      vrf_wdata_o <= '0;
      vrf_wbe_o   <= '0;
      done_o      <= '0;
      err_o       <= 1'b0;
      err_src_o   <= 1'b0;
      pending_o   <= '0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      beat_q      <= beat_d;
      rr_q        <= rr_d;
      vrf_we_o    <= we_d;
      vrf_waddr_o <= waddr_d;
      vrf_wdata_o <= wdata_d;
      vrf_wbe_o   <= wbe_d;
      done_o      <= done_d;
      err_o       <= err_d;
      err_src_o   <= err_src_d;
      pending_o   <= pend_d;
    end
  end

endmodule
